// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
//
// Bundles the producer handshakes, the common data bus broadcast and the
// FIFO occupancy debug outputs of the CDB arbiter.
//
//   alu_valid / alu_rob_id / alu_value / alu_ready : ALU result handshake
//   lsb_valid / lsb_rob_id / lsb_value / lsb_ready : LSB result handshake
//   cdb_valid / cdb_rob_id / cdb_value / cdb_src   : registered broadcast
//   alu_count / lsb_count                          : per-source FIFO occupancy
//
// Modports:
//   master : the producer/consumer side (drives valids, observes the bus)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int ROB_BITS   = 4,
    parameter int DEPTH_BITS = 1
);
    logic                  alu_valid;
    logic [ROB_BITS-1:0]   alu_rob_id;
    logic [31:0]           alu_value;
    logic                  alu_ready;

    logic                  lsb_valid;
    logic [ROB_BITS-1:0]   lsb_rob_id;
    logic [31:0]           lsb_value;
    logic                  lsb_ready;

    logic                  cdb_valid;
    logic [ROB_BITS-1:0]   cdb_rob_id;
    logic [31:0]           cdb_value;
    logic                  cdb_src;

    logic [DEPTH_BITS:0]   alu_count;
    logic [DEPTH_BITS:0]   lsb_count;

    modport master (
        output alu_valid, alu_rob_id, alu_value,
        output lsb_valid, lsb_rob_id, lsb_value,
        input  alu_ready, lsb_ready,
        input  cdb_valid, cdb_rob_id, cdb_value, cdb_src,
        input  alu_count, lsb_count
    );

    modport slave (
        input  alu_valid, alu_rob_id, alu_value,
        input  lsb_valid, lsb_rob_id, lsb_value,
        output alu_ready, lsb_ready,
        output cdb_valid, cdb_rob_id, cdb_value, cdb_src,
        output alu_count, lsb_count
    );
endinterface

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Arbitrates the single common data bus between the ALU and the load/store
// buffer. Each source owns a small FIFO so a producer never has to drop a
// result; when a source's FIFO is empty its live input may bypass straight
// onto the bus. Contention is resolved round-robin, and a RoB clear flushes
// everything back to the reset state.
//
// Ports:
//   clk_in   : system clock
//   rst_in   : synchronous active-low reset
//   rdy_in   : global ready, all state holds while low
//   clear_in : RoB misprediction flush, synchronous
//   bus      : cdb_arbiter_if.slave (producer handshakes, CDB, counts)
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int ROB_BITS   = 4,
    parameter int DEPTH      = 2,
    parameter int DEPTH_BITS = 1
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            clear_in,
    cdb_arbiter_if.slave    bus
);

    localparam logic [DEPTH_BITS:0]   FULL    = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0]   CNT_ONE = (DEPTH_BITS+1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

    logic [ROB_BITS-1:0]   alu_mem_id  [DEPTH];
    logic [31:0]           alu_mem_val [DEPTH];
    logic [DEPTH_BITS-1:0] alu_rd_ptr, alu_wr_ptr;
    logic [DEPTH_BITS:0]   alu_cnt;

    logic [ROB_BITS-1:0]   lsb_mem_id  [DEPTH];
    logic [31:0]           lsb_mem_val [DEPTH];
    logic [DEPTH_BITS-1:0] lsb_rd_ptr, lsb_wr_ptr;
    logic [DEPTH_BITS:0]   lsb_cnt;

    // 1 = LSB was granted last, so the ALU wins the next contention
    logic                  last_grant;

    logic                  cdb_valid_q;
    logic [ROB_BITS-1:0]   cdb_rob_id_q;
    logic [31:0]           cdb_value_q;
    logic                  cdb_src_q;

    logic                  alu_ready, lsb_ready;
    logic                  alu_fire, lsb_fire;
    logic                  alu_has_head, lsb_has_head;
    logic                  alu_cand, lsb_cand;
    logic                  grant_alu, grant_lsb;
    logic                  alu_push, alu_pop, lsb_push, lsb_pop;
    logic [ROB_BITS-1:0]   alu_cand_id, lsb_cand_id;
    logic [31:0]           alu_cand_val, lsb_cand_val;

    // Ready depends only on registered occupancy and rdy_in, never on valid,
    // so producers can't form a combinational loop through it.
    always_comb begin
        alu_ready    = rdy_in && (alu_cnt < FULL);
        lsb_ready    = rdy_in && (lsb_cnt < FULL);
        alu_fire     = bus.alu_valid && alu_ready;
        lsb_fire     = bus.lsb_valid && lsb_ready;
        alu_has_head = (alu_cnt != '0);
        lsb_has_head = (lsb_cnt != '0);
        alu_cand     = alu_has_head || alu_fire;
        lsb_cand     = lsb_has_head || lsb_fire;
    end

    // The FIFO head takes precedence over the live input; bypass is only
    // offered when the FIFO is empty, which keeps per-source ordering.
    always_comb begin
        alu_cand_id  = alu_has_head ? alu_mem_id[alu_rd_ptr]  : bus.alu_rob_id;
        alu_cand_val = alu_has_head ? alu_mem_val[alu_rd_ptr] : bus.alu_value;
        lsb_cand_id  = lsb_has_head ? lsb_mem_id[lsb_rd_ptr]  : bus.lsb_rob_id;
        lsb_cand_val = lsb_has_head ? lsb_mem_val[lsb_rd_ptr] : bus.lsb_value;
    end

    // Round-robin: on contention the source that was not granted last wins.
    // Grants are suppressed while rdy_in is low so nothing pops during a stall.
    always_comb begin
        grant_alu = rdy_in && alu_cand && (!lsb_cand || last_grant);
        grant_lsb = rdy_in && lsb_cand && (!alu_cand || !last_grant);
        alu_pop   = grant_alu && alu_has_head;
        lsb_pop   = grant_lsb && lsb_has_head;
        // A fired input is enqueued unless it went straight onto the bus
        alu_push  = alu_fire && (alu_has_head || !grant_alu);
        lsb_push  = lsb_fire && (lsb_has_head || !grant_lsb);
    end

    // Control state: pointers, counts, round-robin memory and the CDB register.
    always_ff @(posedge clk_in) begin
        if (!rst_in || clear_in) begin
            alu_rd_ptr   <= '0;
            alu_wr_ptr   <= '0;
            alu_cnt      <= '0;
            lsb_rd_ptr   <= '0;
            lsb_wr_ptr   <= '0;
            lsb_cnt      <= '0;
            last_grant   <= 1'b1;
            cdb_valid_q  <= 1'b0;
            cdb_rob_id_q <= '0;
            cdb_value_q  <= '0;
            cdb_src_q    <= 1'b0;
        end else if (rdy_in) begin
            if (alu_push) alu_wr_ptr <= alu_wr_ptr + PTR_ONE;
            if (alu_pop)  alu_rd_ptr <= alu_rd_ptr + PTR_ONE;
            if (alu_push && !alu_pop)      alu_cnt <= alu_cnt + CNT_ONE;
            else if (!alu_push && alu_pop) alu_cnt <= alu_cnt - CNT_ONE;

            if (lsb_push) lsb_wr_ptr <= lsb_wr_ptr + PTR_ONE;
            if (lsb_pop)  lsb_rd_ptr <= lsb_rd_ptr + PTR_ONE;
            if (lsb_push && !lsb_pop)      lsb_cnt <= lsb_cnt + CNT_ONE;
            else if (!lsb_push && lsb_pop) lsb_cnt <= lsb_cnt - CNT_ONE;

            if (grant_alu) begin
                cdb_valid_q  <= 1'b1;
                cdb_rob_id_q <= alu_cand_id;
                cdb_value_q  <= alu_cand_val;
                cdb_src_q    <= 1'b0;
                last_grant   <= 1'b0;
            end else if (grant_lsb) begin
                cdb_valid_q  <= 1'b1;
                cdb_rob_id_q <= lsb_cand_id;
                cdb_value_q  <= lsb_cand_val;
                cdb_src_q    <= 1'b1;
                last_grant   <= 1'b1;
            end else begin
                cdb_valid_q  <= 1'b0;
            end
        end
    end

    // FIFO storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_in) begin
        if (rst_in && !clear_in && alu_push) begin
            alu_mem_id[alu_wr_ptr]  <= bus.alu_rob_id;
            alu_mem_val[alu_wr_ptr] <= bus.alu_value;
        end
        if (rst_in && !clear_in && lsb_push) begin
            lsb_mem_id[lsb_wr_ptr]  <= bus.lsb_rob_id;
            lsb_mem_val[lsb_wr_ptr] <= bus.lsb_value;
        end
    end

    assign bus.alu_ready  = alu_ready;
    assign bus.lsb_ready  = lsb_ready;
    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_rob_id = cdb_rob_id_q;
    assign bus.cdb_value  = cdb_value_q;
    assign bus.cdb_src    = cdb_src_q;
    assign bus.alu_count  = alu_cnt;
    assign bus.lsb_count  = lsb_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed self-checking bench for cdb_arbiter. Inputs are driven 1 ns after
// the rising edge and outputs are sampled at the same point, so every check
// sees the state produced by the edge just taken.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    logic clk_in   = 1'b0;
    logic rst_in   = 1'b0;
    logic rdy_in   = 1'b1;
    logic clear_in = 1'b0;

    int assertCount = 0;
    int failCount   = 0;

    cdb_arbiter_if #(.ROB_BITS(4), .DEPTH_BITS(1)) bus ();

    cdb_arbiter #(
        .ROB_BITS   (4),
        .DEPTH      (2),
        .DEPTH_BITS (1)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .clear_in (clear_in),
        .bus      (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] aluVal(input logic [3:0] id);
        return 32'hA000_0000 | {28'd0, id};
    endfunction

    function automatic logic [31:0] lsbVal(input logic [3:0] id);
        return 32'hB000_0000 | {28'd0, id};
    endfunction

    // Compare one observed value with its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Present one cycle of producer inputs and advance past the next edge
    task automatic applyStimulus(input logic aV, input logic [3:0] aId, input logic [31:0] aVal,
                                 input logic lV, input logic [3:0] lId, input logic [31:0] lVal);
        bus.alu_valid  = aV;
        bus.alu_rob_id = aId;
        bus.alu_value  = aVal;
        bus.lsb_valid  = lV;
        bus.lsb_rob_id = lId;
        bus.lsb_value  = lVal;
        tick();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic doReset();
        rst_in = 1'b0;
        idle();
        idle();
        rst_in = 1'b1;
    endtask

    task automatic checkBus(input string tag, input logic v, input logic [3:0] id,
                            input logic [31:0] val, input logic src);
        checkOutput({tag, ".valid"}, 32'(bus.cdb_valid), 32'(v));
        checkOutput({tag, ".id"},    32'(bus.cdb_rob_id), 32'(id));
        checkOutput({tag, ".value"}, bus.cdb_value, val);
        checkOutput({tag, ".src"},   32'(bus.cdb_src), 32'(src));
    endtask

    task automatic checkCounts(input string tag, input int a, input int l);
        checkOutput({tag, ".alu_count"}, 32'(bus.alu_count), 32'(a));
        checkOutput({tag, ".lsb_count"}, 32'(bus.lsb_count), 32'(l));
    endtask

    // Backpressure expectations: ALU streams 10.., LSB sends 4,5,6
    logic [3:0] bpId  [6] = '{4'd10, 4'd4, 4'd11, 4'd5, 4'd12, 4'd6};
    logic       bpSrc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int         bpAcnt[6] = '{0, 1, 1, 2, 1, 2};
    int         bpLcnt[6] = '{1, 1, 2, 1, 1, 0};

    initial begin
        logic [3:0] aluNext;
        logic [3:0] lsbNext;
        logic       aFire, lFire;

        bus.alu_valid  = 1'b0;
        bus.alu_rob_id = '0;
        bus.alu_value  = '0;
        bus.lsb_valid  = 1'b0;
        bus.lsb_rob_id = '0;
        bus.lsb_value  = '0;

        // Reset state
        doReset();
        checkBus("reset", 1'b0, 4'd0, 32'd0, 1'b0);
        checkOutput("reset.alu_ready", 32'(bus.alu_ready), 32'd1);
        checkOutput("reset.lsb_ready", 32'(bus.lsb_ready), 32'd1);
        checkCounts("reset", 0, 0);

        // Single uncontended ALU result goes out via bypass next cycle
        applyStimulus(1'b1, 4'd3, 32'h1234_5678, 1'b0, 4'd0, 32'd0);
        checkBus("single", 1'b1, 4'd3, 32'h1234_5678, 1'b0);
        checkCounts("single", 0, 0);
        idle();
        checkBus("single.after", 1'b0, 4'd3, 32'h1234_5678, 1'b0);

        // Contention after reset: ALU first, LSB queued then broadcast
        doReset();
        applyStimulus(1'b1, 4'd1, 32'hA, 1'b1, 4'd2, 32'hB);
        checkBus("cont1.n1", 1'b1, 4'd1, 32'hA, 1'b0);
        checkCounts("cont1.n1", 0, 1);
        idle();
        checkBus("cont1.n2", 1'b1, 4'd2, 32'hB, 1'b1);
        checkCounts("cont1.n2", 0, 0);
        // Lone ALU result leaves last_grant on the ALU, so LSB wins next
        applyStimulus(1'b1, 4'd7, aluVal(4'd7), 1'b0, 4'd0, 32'd0);
        checkBus("lone", 1'b1, 4'd7, aluVal(4'd7), 1'b0);
        applyStimulus(1'b1, 4'd8, aluVal(4'd8), 1'b1, 4'd9, lsbVal(4'd9));
        checkBus("cont2.n1", 1'b1, 4'd9, lsbVal(4'd9), 1'b1);
        checkCounts("cont2.n1", 1, 0);
        idle();
        checkBus("cont2.n2", 1'b1, 4'd8, aluVal(4'd8), 1'b0);
        idle();
        checkOutput("cont2.idle", 32'(bus.cdb_valid), 32'd0);

        // Backpressure: ALU streams every cycle, LSB sends 4,5,6
        doReset();
        aluNext = 4'd10;
        lsbNext = 4'd4;
        for (int i = 0; i < 6; i++) begin
            aFire = bus.alu_ready;
            lFire = bus.lsb_ready && (lsbNext <= 4'd6);
            applyStimulus(1'b1, aluNext, aluVal(aluNext),
                          lsbNext <= 4'd6, lsbNext, lsbVal(lsbNext));
            if (aFire) aluNext = aluNext + 4'd1;
            if (lFire) lsbNext = lsbNext + 4'd1;
            checkBus($sformatf("bp%0d", i), 1'b1, bpId[i],
                     bpSrc[i] ? lsbVal(bpId[i]) : aluVal(bpId[i]), bpSrc[i]);
            checkCounts($sformatf("bp%0d", i), bpAcnt[i], bpLcnt[i]);
            if (i == 2) checkOutput("bp.lsb_ready_full", 32'(bus.lsb_ready), 32'd0);
            if (i == 3) checkOutput("bp.alu_ready_full", 32'(bus.alu_ready), 32'd0);
        end

        // Clear mid-operation with alu_count=2, lsb_count=1
        doReset();
        applyStimulus(1'b1, 4'd1, aluVal(4'd1), 1'b1, 4'd2, lsbVal(4'd2));
        applyStimulus(1'b1, 4'd3, aluVal(4'd3), 1'b1, 4'd4, lsbVal(4'd4));
        applyStimulus(1'b1, 4'd5, aluVal(4'd5), 1'b1, 4'd6, lsbVal(4'd6));
        applyStimulus(1'b1, 4'd7, aluVal(4'd7), 1'b0, 4'd0, 32'd0);
        checkBus("preclear", 1'b1, 4'd4, lsbVal(4'd4), 1'b1);
        checkCounts("preclear", 2, 1);
        clear_in = 1'b1;
        applyStimulus(1'b1, 4'd9, aluVal(4'd9), 1'b0, 4'd0, 32'd0);
        clear_in = 1'b0;
        checkBus("clear", 1'b0, 4'd0, 32'd0, 1'b0);
        checkCounts("clear", 0, 0);
        idle();
        checkOutput("clear.dropped", 32'(bus.cdb_valid), 32'd0);
        checkCounts("clear.after", 0, 0);

        // rdy_in stall with alu_valid high and one LSB entry queued
        applyStimulus(1'b1, 4'd1, aluVal(4'd1), 1'b1, 4'd2, lsbVal(4'd2));
        checkBus("prestall", 1'b1, 4'd1, aluVal(4'd1), 1'b0);
        checkCounts("prestall", 0, 1);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'd3, aluVal(4'd3), 1'b0, 4'd0, 32'd0);
            checkOutput($sformatf("stall%0d.alu_ready", i), 32'(bus.alu_ready), 32'd0);
            checkOutput($sformatf("stall%0d.lsb_ready", i), 32'(bus.lsb_ready), 32'd0);
            checkCounts($sformatf("stall%0d", i), 0, 1);
            checkBus($sformatf("stall%0d", i), 1'b1, 4'd1, aluVal(4'd1), 1'b0);
        end
        rdy_in = 1'b1;
        applyStimulus(1'b1, 4'd3, aluVal(4'd3), 1'b0, 4'd0, 32'd0);
        checkBus("resume1", 1'b1, 4'd2, lsbVal(4'd2), 1'b1);
        checkCounts("resume1", 1, 0);
        idle();
        checkBus("resume2", 1'b1, 4'd3, aluVal(4'd3), 1'b0);
        checkCounts("resume2", 0, 0);
        idle();
        checkOutput("resume.idle", 32'(bus.cdb_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
